// File: rtl/dmme_pkg.sv
// dmme_pkg: shared widths, sequencer state encoding and result record for the dmme MAC path
package dmme_pkg;
  localparam int DW_DEF = 16;
  localparam int AW_DEF = 32;
  localparam int MAX_BEATS_DEF = 256;
  localparam int CW_DEF = $clog2(MAX_BEATS_DEF + 1);
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  typedef struct packed {
    logic [AW_DEF-1:0] data;
    logic [CW_DEF-1:0] beats;
    logic              err;
  } res_t;
endpackage

// File: rtl/dmme_mac_seq.sv
// dmme_mac_seq: streams operand beats through an external dual-pair MAC and accumulates one dot product per vector
module dmme_mac_seq
  import dmme_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int MAX_BEATS = MAX_BEATS_DEF,
  localparam int CW = $clog2(MAX_BEATS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_a0,
  input  logic [DW-1:0] in_a1,
  input  logic [DW-1:0] in_b0,
  input  logic [DW-1:0] in_b1,
  input  logic          in_last,
  output logic [DW-1:0] mac_ain0,
  output logic [DW-1:0] mac_ain1,
  output logic [DW-1:0] mac_bin0,
  output logic [DW-1:0] mac_bin1,
  output logic [AW-1:0] mac_csumin,
  input  logic [AW-1:0] mac_csumout,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [AW-1:0] res_data,
  output logic [CW-1:0] res_beats,
  output logic          res_err
);
  state_t state, state_nxt;
  logic [AW-1:0] acc, acc_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic err, err_nxt, fire, hit;
  assign fire = in_valid & in_ready;
  assign cnt_inc = cnt + 1'b1;
  assign hit = cnt_inc == CW'(MAX_BEATS);
  // state, accumulator, beat count and truncation flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      state <= state_nxt;
      acc <= acc_nxt;
      cnt <= cnt_nxt;
      err <= err_nxt;
    end
  end
  // next state: clr wins, then an accepted beat, then the result handshake; IDLE relies on acc being zero
  always_comb begin
    state_nxt = state;
    acc_nxt = acc;
    cnt_nxt = cnt;
    err_nxt = err;
    if (clr) begin
      state_nxt = IDLE;
      acc_nxt = '0;
      cnt_nxt = '0;
      err_nxt = 1'b0;
    end else if (fire) begin
      acc_nxt = mac_csumout;
      cnt_nxt = cnt_inc;
      err_nxt = ~in_last & hit;
      state_nxt = (in_last | hit) ? HOLD : RUN;
    end else if (state == HOLD && res_ready) begin
      state_nxt = IDLE;
      acc_nxt = '0;
      cnt_nxt = '0;
      err_nxt = 1'b0;
    end
  end
  // outputs: MAC pass-through, handshake flags and the registered result
  always_comb begin
    in_ready = rst_n & ~clr & (state != HOLD);
    res_valid = state == HOLD;
    res_data = acc;
    res_beats = cnt;
    res_err = err;
    mac_ain0 = in_a0;
    mac_ain1 = in_a1;
    mac_bin0 = in_b0;
    mac_bin1 = in_b1;
    mac_csumin = acc;
  end
endmodule

// File: tb/tb_dmme_mac_seq.sv
// tb_dmme_mac_seq: random and directed beat streams against a dot-product reference model with a result scoreboard
module tb_dmme_mac_seq;
  import dmme_pkg::*;
  localparam int MB = 4;
  localparam int TCW = $clog2(MB + 1);
  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, res_ready = 1'b0;
  logic [15:0] in_a0 = '0, in_a1 = '0, in_b0 = '0, in_b1 = '0;
  logic in_ready, res_valid, res_err;
  logic [15:0] mac_ain0, mac_ain1, mac_bin0, mac_bin1;
  logic [31:0] mac_csumin, mac_csumout, res_data;
  logic [TCW-1:0] res_beats;
  int checks = 0, errors = 0;
  logic bp = 1'b1;
  logic held = 1'b0;
  res_t q[$];
  res_t cur;
  logic [31:0] exp_acc = '0;
  int exp_cnt = 0;

  dmme_mac_seq #(.DW(16), .AW(32), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a0(in_a0), .in_a1(in_a1), .in_b0(in_b0), .in_b1(in_b1), .in_last(in_last),
    .mac_ain0(mac_ain0), .mac_ain1(mac_ain1), .mac_bin0(mac_bin0), .mac_bin1(mac_bin1),
    .mac_csumin(mac_csumin), .mac_csumout(mac_csumout),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_beats(res_beats), .res_err(res_err)
  );

  assign mac_csumout = 32'(mac_ain0) * 32'(mac_bin0) + 32'(mac_ain1) * 32'(mac_bin1) + mac_csumin;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_beat(input logic [15:0] a0, input logic [15:0] a1,
                           input logic [15:0] b0, input logic [15:0] b1, input logic last);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_a0 = a0; in_a1 = a1; in_b0 = b0; in_b1 = b1; in_last = last;
    #1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      chk("ready_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    exp_acc = exp_acc + 32'(a0) * 32'(b0) + 32'(a1) * 32'(b1);
    exp_cnt++;
    if (last || exp_cnt == MB) begin
      q.push_back('{data: exp_acc, beats: CW_DEF'(exp_cnt), err: !last});
      exp_acc = '0;
      exp_cnt = 0;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bp = 1'b0;
    while ((q.size() != 0 || res_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue", 64'(q.size()), 64'd0);
  endtask

  task automatic wait_held();
    int n = 0;
    while (!held && n < 200) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("hold_reached", 64'(held), 64'd1);
  endtask

  initial forever begin
    @(negedge clk);
    res_ready = bp ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  initial forever begin
    @(negedge clk);
    #2;
    if (!rst_n || !res_valid) held = 1'b0;
    else if (!held) begin
      held = 1'b1;
      if (q.size() == 0) chk("unexpected_result", 64'(res_data), 64'd0);
      else begin
        cur = q.pop_front();
        chk("res_data", 64'(res_data), 64'(cur.data));
        chk("res_beats", 64'(res_beats), 64'(cur.beats));
        chk("res_err", 64'(res_err), 64'(cur.err));
      end
    end else begin
      chk("hold_data_stable", 64'(res_data), 64'(cur.data));
      chk("hold_beats_stable", 64'(res_beats), 64'(cur.beats));
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
  end

  initial begin
    int len;
    logic lst;
    #3;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_res_beats", 64'(res_beats), 64'd0);
    chk("rst_res_err", 64'(res_err), 64'd0);
    chk("rst_csumin", 64'(mac_csumin), 64'd0);
    in_a1 = 16'h1234;
    in_b0 = 16'h00a5;
    #1;
    chk("mac_ain1_pass", 64'(mac_ain1), 64'h1234);
    chk("mac_bin0_pass", 64'(mac_bin0), 64'h00a5);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    bp = 1'b0;
    send_beat(16'd3, 16'd4, 16'd5, 16'd6, 1'b1);
    send_beat(16'd3, 16'd4, 16'd5, 16'd6, 1'b0);
    send_beat(16'd1234, 16'd5678, 16'd9123, 16'd4567, 1'b1);
    send_beat(16'hffff, 16'hffff, 16'hffff, 16'hffff, 1'b1);
    send_beat(16'hffff, 16'hffff, 16'hffff, 16'hffff, 1'b0);
    send_beat(16'hffff, 16'hffff, 16'hffff, 16'hffff, 1'b1);
    for (int i = 0; i < MB; i++) send_beat(16'd1, 16'd0, 16'd1, 16'd0, 1'b0);
    for (int i = 0; i < MB; i++) send_beat(16'd2, 16'd1, 16'd3, 16'd1, i == MB - 1);
    drain();
    bp = 1'b1;
    fork
      begin
        repeat (6) @(negedge clk);
        bp = 1'b0;
      end
      begin
        send_beat(16'd7, 16'd8, 16'd9, 16'd10, 1'b1);
        send_beat(16'd11, 16'd0, 16'd2, 16'd0, 1'b1);
      end
    join
    drain();
    send_beat(16'd100, 16'd200, 16'd300, 16'd400, 1'b0);
    send_beat(16'd5, 16'd6, 16'd7, 16'd8, 1'b0);
    @(negedge clk);
    clr = 1'b1;
    exp_acc = '0;
    exp_cnt = 0;
    #1;
    chk("clr_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    clr = 1'b0;
    send_beat(16'd3, 16'd4, 16'd5, 16'd6, 1'b1);
    drain();
    bp = 1'b1;
    send_beat(16'd9, 16'd9, 16'd9, 16'd9, 1'b1);
    wait_held();
    rst_n = 1'b0;
    #1;
    chk("rst_hold_valid", 64'(res_valid), 64'd0);
    chk("rst_hold_data", 64'(res_data), 64'd0);
    chk("rst_hold_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bp = 1'b0;
    send_beat(16'd3, 16'd4, 16'd5, 16'd6, 1'b1);
    for (int v = 0; v < 40; v++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 1) * $urandom_range(1, 3)) @(negedge clk);
        lst = (i == len - 1) && ($urandom_range(0, 4) != 0);
        send_beat(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), lst);
      end
    end
    send_beat(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b1);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
